cpu_divider: RTL and testbench

CPU_DIVIDER -- requirements
Module: cpu_divider

---
 rtl/cpu_divider.sv | 159 +++++++++++++++
 tb/tb_cpu_divider.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_divider.sv
// cpu_divider: multi-cycle 32-bit integer divider for the CPU.
// Signed and unsigned quotient/remainder via a restoring shift-subtract loop:
// one capture cycle, 32 RUN steps and one FIX cycle that applies the signs.
// The result is pushed to the read-return FIFO with a one-cycle strobe.
// A result tagged with register 0 is never pushed, because that tag marks an
// empty FIFO slot.
module cpu_divider (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] numerator,
    input  logic [31:0] denominator,
    input  logic [4:0]  dest_reg,
    output logic        busy,
    output logic        div_valid,
    output logic [31:0] div_result,
    output logic [4:0]  div_dest_reg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [4:0]  count_q;      // RUN step counter, 0..31
    logic [32:0] rem_q;        // partial remainder
    logic [31:0] quo_q;        // dividend shifts out, quotient bits shift in
    logic [31:0] dsr_q;        // divisor magnitude
    logic        is_mod_q;     // op returns the remainder
    logic        neg_quo_q;    // quotient must be negated in FIX
    logic        neg_rem_q;    // remainder must be negated in FIX
    logic        div_zero_q;   // divisor was zero
    logic [4:0]  dest_q;       // tag captured at start

    logic        valid_q;
    logic [31:0] result_q;
    logic [4:0]  result_dest_q;

    // Operand conditioning for the capture cycle
    logic        op_signed;
    logic        num_neg;
    logic        den_neg;
    logic [31:0] num_mag;
    logic [31:0] den_mag;

    // One restoring step and the sign fix-up
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        step_ok;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;

    // State register; reset wins over any start in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN on start, 32 RUN steps, one FIX cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (count_q == 5'd31) state_d = FIX;
            FIX:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the state
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Operand magnitudes, shift-subtract step and sign application
    always_comb begin
        op_signed = ~op[0];
        num_neg   = op_signed & numerator[31];
        den_neg   = op_signed & denominator[31];
        num_mag   = num_neg ? (~numerator + 32'd1) : numerator;
        den_mag   = den_neg ? (~denominator + 32'd1) : denominator;

        // A negative difference shows up as bit 32 set, since the partial
        // remainder is always below the divisor before the shift.
        rem_shift = {rem_q[31:0], quo_q[31]};
        rem_diff  = rem_shift - {1'b0, dsr_q};
        step_ok   = ~rem_diff[32];

        // Divide by zero yields all ones for the quotient regardless of sign;
        // the remainder path naturally reproduces the original numerator.
        if (div_zero_q) begin
            quo_fixed = 32'hFFFF_FFFF;
        end else if (neg_quo_q) begin
            quo_fixed = ~quo_q + 32'd1;
        end else begin
            quo_fixed = quo_q;
        end
        rem_fixed = neg_rem_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    end

    // Datapath: capture in IDLE, iterate in RUN, register the result in FIX
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 5'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        count_q    <= 5'd0;
                        rem_q      <= 33'd0;
                        quo_q      <= num_mag;
                        dsr_q      <= den_mag;
                        is_mod_q   <= op[1];
                        neg_quo_q  <= num_neg ^ den_neg;
                        neg_rem_q  <= num_neg;
                        div_zero_q <= (denominator == 32'd0);
                        dest_q     <= dest_reg;
                    end
                end
                RUN: begin
                    count_q <= count_q + 5'd1;
                    rem_q   <= step_ok ? rem_diff : rem_shift;
                    quo_q   <= {quo_q[30:0], step_ok};
                end
                FIX: begin
                    result_q      <= is_mod_q ? rem_fixed : quo_fixed;
                    result_dest_q <= dest_q;
                    valid_q       <= (dest_q != 5'd0);
                end
                default: begin
                    count_q <= 5'd0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Flag a start that arrives while an operation is still in flight
    always_ff @(posedge clock) begin
        if (!reset && start && (state_q != IDLE)) begin
            $display("ERROR cpu_divider: start ignored while busy (t=%0t)", $time);
        end
    end
`endif

    assign div_valid    = valid_q;
    assign div_result   = result_q;
    assign div_dest_reg = result_dest_q;

endmodule

// File: tb/tb_cpu_divider.sv
// tb_cpu_divider: directed corner cases plus randomized divides, all checked
// against a plain-arithmetic reference of the divider's rules.
module tb_cpu_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] numerator;
    logic [31:0] denominator;
    logic [4:0]  dest_reg;
    logic        busy;
    logic        div_valid;
    logic [31:0] div_result;
    logic [4:0]  div_dest_reg;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    cpu_divider dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .numerator    (numerator),
        .denominator  (denominator),
        .dest_reg     (dest_reg),
        .busy         (busy),
        .div_valid    (div_valid),
        .div_result   (div_result),
        .div_dest_reg (div_dest_reg)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: 00 DIVS, 01 DIVU, 10 MODS, 11 MODU
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] n,
                                               input logic [31:0] d);
        int sn;
        int sd;
        if (d == 32'd0)
            return o[1] ? n : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF)
                return o[1] ? 32'd0 : 32'h8000_0000;
            sn = n;
            sd = d;
            return o[1] ? 32'(sn % sd) : 32'(sn / sd);
        end
        return o[1] ? (n % d) : (n / d);
    endfunction

    // Called on a falling edge; the start pulse is sampled at the next rising edge
    task automatic launch(input logic [1:0] o, input logic [31:0] n, input logic [31:0] d,
                          input logic [4:0] dr);
        op          = o;
        numerator   = n;
        denominator = d;
        dest_reg    = dr;
        start       = 1'b1;
        @(negedge clock);
        start       = 1'b0;
    endtask

    // Bounded wait for the strobe, counting busy cycles on the way
    task automatic wait_valid(output bit seen, output int busy_cnt);
        seen     = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (div_valid) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clock);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] n,
                          input logic [31:0] d, input logic [4:0] dr, input logic [31:0] exp);
        bit seen;
        int bc;
        int t0;
        launch(o, n, d, dr);
        t0 = cyc;
        wait_valid(seen, bc);
        check({tag, ".busy_cycles"}, 32'(bc), 32'd33);
        if (dr != 5'd0) begin
            check({tag, ".valid"}, 32'(seen), 32'd1);
            check({tag, ".latency"}, 32'(cyc - t0), 32'd33);
            check({tag, ".result"}, div_result, exp);
            check({tag, ".dest"}, 32'(div_dest_reg), 32'(dr));
            check({tag, ".busy_at_valid"}, 32'(busy), 32'd0);
            @(negedge clock);
            check({tag, ".valid_one_cycle"}, 32'(div_valid), 32'd0);
            check({tag, ".result_held"}, div_result, exp);
        end else begin
            check({tag, ".no_valid"}, 32'(seen), 32'd0);
        end
        $display("op=%0d n=0x%08h d=0x%08h dest=%0d -> 0x%08h (exp 0x%08h)",
                 o, n, d, dr, div_result, exp);
    endtask

    initial begin
        bit          seen;
        int          bc;
        int          t1;
        int          extra;
        logic [1:0]  ro;
        logic [31:0] rn;
        logic [31:0] rd;
        logic [4:0]  rdest;

        reset = 1'b1; start = 1'b0; op = 2'd0;
        numerator = 32'd0; denominator = 32'd0; dest_reg = 5'd0;
        repeat (3) @(negedge clock);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.valid", 32'(div_valid), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed cases
        run_op("divu_100_7",    2'd1, 32'd100,          32'd7,          5'd5,  32'h0000_000E);
        run_op("divs_neg7_2",   2'd0, 32'hFFFF_FFF9,    32'd2,          5'd1,  32'hFFFF_FFFD);
        run_op("mods_neg7_2",   2'd2, 32'hFFFF_FFF9,    32'd2,          5'd2,  32'hFFFF_FFFF);
        run_op("modu_big_2",    2'd3, 32'hFFFF_FFF9,    32'd2,          5'd3,  32'h0000_0001);
        run_op("divu_by0",      2'd1, 32'd123,          32'd0,          5'd4,  32'hFFFF_FFFF);
        run_op("mods_by0",      2'd2, 32'hFFFF_FF85,    32'd0,          5'd6,  32'hFFFF_FF85);
        run_op("divs_ovf",      2'd0, 32'h8000_0000,    32'hFFFF_FFFF,  5'd7,  32'h8000_0000);
        run_op("mods_ovf",      2'd2, 32'h8000_0000,    32'hFFFF_FFFF,  5'd8,  32'h0000_0000);
        run_op("dest0",         2'd1, 32'd50,           32'd5,          5'd0,  32'd10);

        // Reset during the 10th RUN cycle aborts the operation
        launch(2'd1, 32'd1000, 32'd3, 5'd9);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort.busy", 32'(busy), 32'd0);
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (div_valid) extra++;
        end
        check("abort.no_valid", 32'(extra), 32'd0);

        // Reset and start together: start is dropped
        op = 2'd1; numerator = 32'd9; denominator = 32'd3; dest_reg = 5'd10;
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        check("rst_start.busy", 32'(busy), 32'd0);
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (div_valid) extra++;
        end
        check("rst_start.no_valid", 32'(extra), 32'd0);

        // Start while busy is ignored
        launch(2'd1, 32'd77, 32'd7, 5'd11);
        repeat (5) @(negedge clock);
        launch(2'd3, 32'd1234, 32'd10, 5'd12);
        wait_valid(seen, bc);
        check("contend.valid", 32'(seen), 32'd1);
        check("contend.result", div_result, 32'd11);
        check("contend.dest", 32'(div_dest_reg), 32'd11);
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (div_valid) extra++;
        end
        check("contend.single_valid", 32'(extra), 32'd0);

        // Back-to-back: second start in the div_valid cycle
        launch(2'd1, 32'd1000, 32'd10, 5'd13);
        wait_valid(seen, bc);
        check("b2b.first_result", div_result, 32'd100);
        t1 = cyc;
        launch(2'd0, 32'hFFFF_FF9C, 32'd7, 5'd14);
        wait_valid(seen, bc);
        check("b2b.second_valid", 32'(seen), 32'd1);
        check("b2b.spacing", 32'(cyc - t1), 32'd34);
        check("b2b.second_result", div_result, ref_result(2'd0, 32'hFFFF_FF9C, 32'd7));
        check("b2b.second_dest", 32'(div_dest_reg), 32'd14);
        @(negedge clock);

        // Randomized operations against the reference
        for (int k = 0; k < 24; k++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: rn = $urandom_range(0, 1000);
                1: rn = 32'h8000_0000 | $urandom;
                default: rn = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rd = 32'd0;
                1: rd = $urandom_range(1, 20);
                2: rd = 32'hFFFF_FFFF - $urandom_range(0, 20);
                3: rd = $urandom & 32'h0000_FFFF;
                default: rd = $urandom;
            endcase
            rdest = 5'($urandom_range(1, 31));
            run_op($sformatf("rand%0d", k), ro, rn, rd, rdest, ref_result(ro, rn, rd));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
